// File: rtl/hdmi_audio_pkg.sv
// Shared constants and types for the HDMI audio sample packet path:
// packet type, IEC 60958 frame length, subpacket flag positions, channel-status fields.
package hdmi_audio_pkg;

  localparam logic [7:0] PKT_TYPE_AUDIO_SAMPLE = 8'h02;
  localparam int         IEC_FRAMES            = 192;

  localparam int SP_WIDTH = 56;
  localparam int SP_COUNT = 4;

  // Per-subpacket status flags sit above the two 24-bit audio fields.
  localparam int SP_VL = 48;
  localparam int SP_UL = 49;
  localparam int SP_CL = 50;
  localparam int SP_PL = 51;
  localparam int SP_VR = 52;
  localparam int SP_UR = 53;
  localparam int SP_CR = 54;
  localparam int SP_PR = 55;

  localparam int CS_CATEGORY_LSB = 8;
  localparam int CS_CHANNEL_LSB  = 20;
  localparam int CS_FREQ_LSB     = 24;
  localparam int CS_WLEN_LSB     = 32;

  localparam logic [3:0] CS_CHAN_LEFT  = 4'd1;
  localparam logic [3:0] CS_CHAN_RIGHT = 4'd2;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_READ,
    ST_PRESENT
  } packer_state_e;

  // Even parity: P makes the total number of ones over audio, V, U, C and P even.
  function automatic logic even_parity(input logic [23:0] audio, input logic v,
                                       input logic u, input logic c);
    return ^{audio, v, u, c};
  endfunction

endpackage

// File: rtl/iec60958_channel_status.sv
// Combinational lookup of one IEC 60958 channel-status bit for a given frame and channel.
module iec60958_channel_status
  import hdmi_audio_pkg::*;
(
  input  logic [7:0] frame_index_i,
  input  logic       channel_i,
  input  logic [7:0] category_i,
  input  logic [3:0] sampling_freq_i,
  input  logic [3:0] word_length_i,
  output logic       c_bit_o
);

  logic [3:0] chan_num;
  logic [7:0] rel_cat;
  logic [7:0] rel_chan;
  logic [7:0] rel_freq;
  logic [7:0] rel_wlen;

  always_comb begin
    chan_num = channel_i ? CS_CHAN_RIGHT : CS_CHAN_LEFT;
    rel_cat  = frame_index_i - 8'(CS_CATEGORY_LSB);
    rel_chan = frame_index_i - 8'(CS_CHANNEL_LSB);
    rel_freq = frame_index_i - 8'(CS_FREQ_LSB);
    rel_wlen = frame_index_i - 8'(CS_WLEN_LSB);
    c_bit_o  = 1'b0;
    // Unsigned wrap-around makes "rel < width" a full range test.
    if (rel_cat < 8'd8) begin
      c_bit_o = category_i[rel_cat[2:0]];
    end else if (rel_chan < 8'd4) begin
      c_bit_o = chan_num[rel_chan[1:0]];
    end else if (rel_freq < 8'd4) begin
      c_bit_o = sampling_freq_i[rel_freq[1:0]];
    end else if (rel_wlen < 8'd4) begin
      c_bit_o = word_length_i[rel_wlen[1:0]];
    end
  end

endmodule

// File: rtl/hdmi_audio_sample_packer.sv
// Pops stereo PCM words from the audio FIFO and assembles HDMI Audio Sample Packets
// (layout 0, up to four subpackets) with IEC 60958 status bits for the island scheduler.
module hdmi_audio_sample_packer
  import hdmi_audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                      pixelClock,
  input  logic                      resetN,
  input  logic                      sampleFifoEmpty,
  input  logic [2*SAMPLE_WIDTH-1:0] sampleFifoReadData,
  output logic                      sampleFifoReadEnable,
  input  logic                      flush,
  input  logic [7:0]                spdifCategoryCode,
  input  logic [3:0]                spdifSamplingFreq,
  input  logic [3:0]                spdifWordLength,
  output logic                      packetValid,
  input  logic                      packetReady,
  output logic [23:0]               packetHeader,
  output logic [223:0]              packetBody
);

  localparam int SHIFT = 24 - SAMPLE_WIDTH;

  packer_state_e state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [7:0]    frame_idx_q, frame_idx_d;
  logic          flush_pend_q, flush_pend_d;
  logic [SP_COUNT-1:0][SP_WIDTH-1:0] slot_q, slot_d;
  logic [SP_COUNT-1:0] b_flag_q, b_flag_d;
  logic          valid_q, valid_d;
  logic [23:0]   header_q, header_d;
  logic [223:0]  body_q, body_d;

  logic          pop;
  logic          handshake;
  logic [23:0]   left_aud;
  logic [23:0]   right_aud;
  logic [1:0]    cs_bit;
  logic [SP_WIDTH-1:0] new_sp;
  logic [3:0]    present_mask;

  // Gated by resetN so the pop request is low while reset is held.
  assign pop = resetN && (state_q == ST_COLLECT) && !sampleFifoEmpty &&
               (count_q < 3'd4) && !flush_pend_q;
  assign handshake = valid_q && packetReady;

  assign left_aud  = 24'(sampleFifoReadData[2*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH]) << SHIFT;
  assign right_aud = 24'(sampleFifoReadData[SAMPLE_WIDTH-1:0]) << SHIFT;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cs
    iec60958_channel_status u_cs (
      .frame_index_i   (frame_idx_q),
      .channel_i       (1'(gi)),
      .category_i      (spdifCategoryCode),
      .sampling_freq_i (spdifSamplingFreq),
      .word_length_i   (spdifWordLength),
      .c_bit_o         (cs_bit[gi])
    );
  end

  always_comb begin
    new_sp        = '0;
    new_sp[23:0]  = left_aud;
    new_sp[47:24] = right_aud;
    new_sp[SP_VL] = 1'b0;
    new_sp[SP_UL] = 1'b0;
    new_sp[SP_CL] = cs_bit[0];
    new_sp[SP_PL] = even_parity(left_aud, 1'b0, 1'b0, cs_bit[0]);
    new_sp[SP_VR] = 1'b0;
    new_sp[SP_UR] = 1'b0;
    new_sp[SP_CR] = cs_bit[1];
    new_sp[SP_PR] = even_parity(right_aud, 1'b0, 1'b0, cs_bit[1]);
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    frame_idx_d  = frame_idx_q;
    flush_pend_d = flush_pend_q;
    slot_d       = slot_q;
    b_flag_d     = b_flag_q;
    valid_d      = valid_q;
    header_d     = header_q;
    body_d       = body_q;
    present_mask = 4'h0;

    case (state_q)
      ST_COLLECT: begin
        if (flush && (count_q != 3'd0 || pop)) begin
          flush_pend_d = 1'b1;
        end
        if (pop) begin
          state_d = ST_READ;
        end else if (flush_pend_q && count_q != 3'd0) begin
          state_d = ST_PRESENT;
        end
      end
      ST_READ: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        slot_d[count_q[1:0]]   = new_sp;
        b_flag_d[count_q[1:0]] = (frame_idx_q == 8'd0);
        count_d     = count_q + 3'd1;
        frame_idx_d = (frame_idx_q == 8'(IEC_FRAMES - 1)) ? 8'd0 : frame_idx_q + 8'd1;
        if (count_d == 3'd4 || flush_pend_q) begin
          state_d = ST_PRESENT;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_PRESENT: begin
        if (handshake) begin
          state_d      = ST_COLLECT;
          count_d      = 3'd0;
          slot_d       = '0;
          b_flag_d     = '0;
          flush_pend_d = 1'b0;
          valid_d      = 1'b0;
          header_d     = '0;
          body_d       = '0;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    // Snapshot the packet on entry to PRESENT so outputs hold until the handshake.
    if (state_d == ST_PRESENT && state_q != ST_PRESENT) begin
      present_mask = 4'((5'd1 << count_d) - 5'd1);
      flush_pend_d = 1'b0;
      valid_d      = 1'b1;
      header_d     = {b_flag_d, 4'h0, 4'h0, present_mask, PKT_TYPE_AUDIO_SAMPLE};
      body_d       = slot_d;
    end
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_COLLECT;
      count_q      <= 3'd0;
      frame_idx_q  <= 8'd0;
      flush_pend_q <= 1'b0;
      slot_q       <= '0;
      b_flag_q     <= '0;
      valid_q      <= 1'b0;
      header_q     <= '0;
      body_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      frame_idx_q  <= frame_idx_d;
      flush_pend_q <= flush_pend_d;
      slot_q       <= slot_d;
      b_flag_q     <= b_flag_d;
      valid_q      <= valid_d;
      header_q     <= header_d;
      body_q       <= body_d;
    end
  end

  assign sampleFifoReadEnable = pop;
  assign packetValid          = valid_q;
  assign packetHeader         = header_q;
  assign packetBody           = body_q;

endmodule

// File: tb/tb_hdmi_audio_sample_packer.sv
// Directed bench for hdmi_audio_sample_packer with a queue-backed FIFO model.
module tb_hdmi_audio_sample_packer;

  localparam int SW = 16;

  logic          pixelClock = 1'b0;
  logic          resetN;
  logic          sampleFifoEmpty;
  logic [2*SW-1:0] sampleFifoReadData;
  logic          sampleFifoReadEnable;
  logic          flush;
  logic [7:0]    spdifCategoryCode;
  logic [3:0]    spdifSamplingFreq;
  logic [3:0]    spdifWordLength;
  logic          packetValid;
  logic          packetReady;
  logic [23:0]   packetHeader;
  logic [223:0]  packetBody;

  int n_pass  = 0;
  int n_total = 0;
  int pops    = 0;
  logic [31:0] fifo_q [$];

  always #5 pixelClock = ~pixelClock;

  hdmi_audio_sample_packer #(.SAMPLE_WIDTH(SW)) dut (
    .pixelClock           (pixelClock),
    .resetN               (resetN),
    .sampleFifoEmpty      (sampleFifoEmpty),
    .sampleFifoReadData   (sampleFifoReadData),
    .sampleFifoReadEnable (sampleFifoReadEnable),
    .flush                (flush),
    .spdifCategoryCode    (spdifCategoryCode),
    .spdifSamplingFreq    (spdifSamplingFreq),
    .spdifWordLength      (spdifWordLength),
    .packetValid          (packetValid),
    .packetReady          (packetReady),
    .packetHeader         (packetHeader),
    .packetBody           (packetBody)
  );

  task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    sampleFifoEmpty = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge; models FIFO read latency.
  task automatic cyc();
    logic popped;
    #1;
    popped = sampleFifoReadEnable;
    if (popped) pops++;
    @(posedge pixelClock);
    #1;
    if (popped && fifo_q.size() > 0) sampleFifoReadData = fifo_q.pop_front();
    sampleFifoEmpty = (fifo_q.size() == 0);
    @(negedge pixelClock);
  endtask

  task automatic wait_valid(input int max_cycles, output int cycles);
    cycles = 0;
    while (!packetValid && cycles < max_cycles) begin
      cyc();
      cycles++;
    end
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    fifo_q.delete();
    sampleFifoEmpty = 1'b1;
    flush = 1'b0;
    packetReady = 1'b0;
    @(negedge pixelClock);
    @(negedge pixelClock);
    resetN = 1'b1;
  endtask

  function automatic logic [55:0] sp(input logic [15:0] l, input logic [15:0] r,
                                     input logic cl, input logic cr);
    logic pl, pr;
    pl = (^l) ^ cl;
    pr = (^r) ^ cr;
    return {pr, cr, 2'b00, pl, cl, 2'b00, r, 8'h00, l, 8'h00};
  endfunction

  // Hand-derived C=1 frames for category 0x40, freq 2, word length 0xB.
  function automatic logic exp_cl(input int f);
    return (f == 14) || (f == 20) || (f == 25) || (f == 32) || (f == 33) || (f == 35);
  endfunction

  function automatic logic exp_cr(input int f);
    return (f == 14) || (f == 21) || (f == 25) || (f == 32) || (f == 33) || (f == 35);
  endfunction

  initial begin
    int lat;
    int pkt;
    int guard;
    logic stable;
    logic [23:0]  h0;
    logic [223:0] b0;
    logic [223:0] exp_body;
    logic [3:0]   exp_b;

    resetN = 1'b0;
    flush = 1'b0;
    packetReady = 1'b0;
    sampleFifoEmpty = 1'b1;
    sampleFifoReadData = '0;
    spdifCategoryCode = 8'h00;
    spdifSamplingFreq = 4'h0;
    spdifWordLength = 4'h0;

    // Reset state
    @(negedge pixelClock);
    chk("rst_rden",   224'(sampleFifoReadEnable), 224'(1'b0));
    chk("rst_valid",  224'(packetValid), 224'(1'b0));
    chk("rst_header", 224'(packetHeader), 224'(24'h0));
    chk("rst_body",   packetBody, 224'(0));

    // Four full samples, consumer always ready
    do_reset();
    packetReady = 1'b1;
    pops = 0;
    repeat (4) push(32'h1234_ABCD);
    #1;
    chk("t1_first_pop", 224'(sampleFifoReadEnable), 224'(1'b1));
    wait_valid(20, lat);
    chk("t1_latency", 224'(lat), 224'(8));
    chk("t1_header", 224'(packetHeader), 224'(24'h100F02));
    chk("t1_sp0_audio", 224'(packetBody[47:0]), 224'(48'hABCD00_123400));
    chk("t1_body", packetBody, {4{56'h08_ABCD00_123400}});
    repeat (4) cyc();
    chk("t1_pops", 224'(pops), 224'(4));
    chk("t1_valid_off", 224'(packetValid), 224'(1'b0));

    // Single word plus flush; also parity of 0x0001 / 0x0003
    do_reset();
    pops = 0;
    push(32'h0001_0003);
    repeat (4) cyc();
    chk("t2_no_valid_pre_flush", 224'(packetValid), 224'(1'b0));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t2_valid_after_1", 224'(packetValid), 224'(1'b0));
    cyc();
    chk("t2_valid_after_2", 224'(packetValid), 224'(1'b1));
    chk("t2_header", 224'(packetHeader), 224'(24'h100102));
    chk("t2_sp123_zero", 224'(packetBody[223:56]), 224'(0));
    chk("t2_sp0", 224'(packetBody[55:0]), 224'(56'h08_000300_000100));
    chk("t2_parity_0001", 224'(packetBody[51]), 224'(1'b1));
    chk("t2_parity_0003", 224'(packetBody[55]), 224'(1'b0));

    // Back-pressure: hold packetReady low 50 cycles with words waiting
    repeat (4) push(32'h0F0F_F0F0);
    h0 = packetHeader;
    b0 = packetBody;
    stable = 1'b1;
    repeat (50) begin
      cyc();
      if (packetHeader !== h0 || packetBody !== b0 || packetValid !== 1'b1) stable = 1'b0;
    end
    chk("t4_hold_stable", 224'(stable), 224'(1'b1));
    chk("t4_no_pops_held", 224'(pops), 224'(1));
    packetReady = 1'b1;
    cyc();
    chk("t4_resume_pop", 224'(sampleFifoReadEnable), 224'(1'b1));
    chk("t4_valid_dropped", 224'(packetValid), 224'(1'b0));
    chk("t4_header_cleared", 224'(packetHeader), 224'(24'h0));
    wait_valid(20, lat);
    chk("t4_next_latency", 224'(lat), 224'(8));
    chk("t4_next_header", 224'(packetHeader), 224'(24'h000F02));
    chk("t4_next_body", packetBody, {4{sp(16'h0F0F, 16'hF0F0, 1'b0, 1'b0)}});

    // 200 streamed zero samples: B flags and channel-status bits
    spdifCategoryCode = 8'h40;
    spdifSamplingFreq = 4'h2;
    spdifWordLength = 4'hB;
    do_reset();
    packetReady = 1'b1;
    repeat (200) push(32'h0);
    pkt = 0;
    guard = 0;
    while (pkt < 50 && guard < 2000) begin
      if (packetValid) begin
        exp_body = '0;
        exp_b = '0;
        for (int n = 0; n < 4; n++) begin
          int f;
          f = (4 * pkt + n) % 192;
          exp_body[n*56 +: 56] = sp(16'h0, 16'h0, exp_cl(f), exp_cr(f));
          exp_b[n] = (f == 0);
        end
        chk($sformatf("t3_hdr_p%0d", pkt), 224'(packetHeader), 224'({exp_b, 4'h0, 8'h0F, 8'h02}));
        chk($sformatf("t3_body_p%0d", pkt), packetBody, exp_body);
        pkt++;
      end
      cyc();
      guard++;
    end
    chk("t3_packet_count", 224'(pkt), 224'(50));

    // Reset in the middle of collection
    spdifCategoryCode = 8'h00;
    spdifSamplingFreq = 4'h0;
    spdifWordLength = 4'h0;
    do_reset();
    push(32'h1111_2222);
    push(32'h3333_4444);
    repeat (4) cyc();
    push(32'h7777_8888);
    #1;
    chk("t5_pop_before_reset", 224'(sampleFifoReadEnable), 224'(1'b1));
    #1;
    resetN = 1'b0;
    #1;
    chk("t5_rst_rden",  224'(sampleFifoReadEnable), 224'(1'b0));
    chk("t5_rst_valid", 224'(packetValid), 224'(1'b0));
    chk("t5_rst_hdr",   224'(packetHeader), 224'(24'h0));
    chk("t5_rst_body",  packetBody, 224'(0));
    fifo_q.delete();
    sampleFifoEmpty = 1'b1;
    @(negedge pixelClock);
    @(negedge pixelClock);
    resetN = 1'b1;
    push(32'h5555_0000);
    repeat (3) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    chk("t5_flush_valid", 224'(packetValid), 224'(1'b1));
    chk("t5_header", 224'(packetHeader), 224'(24'h100102));
    chk("t5_body", packetBody, 224'(sp(16'h5555, 16'h0000, 1'b0, 1'b0)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
